mac_pe_row: RTL and testbench
=============================

Name: mac_pe_row

Overview:
Parametrised weight-stationary row of NUM_PE signed fixed-point MAC stages for the LSTM gate datapath. Each accepted input vector flows through a registered partial-sum chain, one stage per PE. The row accumulates across multiple vector tiles (in_first/in_last), then rounds and saturates the dot product to OUT_WIDTH. Valid/ready handshakes on both sides give full-row backpressure; a weight-load port holds the stationary weights.

Parameters:
NUM_PE, 4, number of MAC stages (vector length per tile), >=2
DATA_WIDTH, 12, signed width of data and weight elements
ACC_WIDTH, 32, signed partial-sum/accumulator width, >= 2*DATA_WIDTH+clog2(NUM_PE)+4
OUT_WIDTH, 12, signed result width
FRAC_BITS, 8, fractional bits of the Q-format, >=1; result = round(acc >> FRAC_BITS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
w_we  in  1  weight write strobe
w_idx  in  clog2(NUM_PE)  target PE index
w_data  in  DATA_WIDTH  signed weight value
w_err  out  1  sticky: a weight write was attempted while busy
in_valid  in  1  input vector valid
in_ready  out  1  row accepts a vector this cycle
in_data  in  NUM_PE*DATA_WIDTH  element i at bits [i*DATA_WIDTH +: DATA_WIDTH], signed
in_first  in  1  first tile of a dot product: clears the accumulator
in_last  in  1  last tile of a dot product: produces an output
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  OUT_WIDTH  signed rounded, saturated result
out_sat  out  1  out_data was clipped; qualified by out_valid
busy  out  1  any pipeline stage holds a valid vector

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, all pipeline registers 0, weights 0, accumulator 0. out_valid=0, out_data=0, out_sat=0, w_err=0. Reset mid-operation drops in-flight vectors with no output.
- adv = !out_valid || out_ready.
- in_ready = adv && !w_we. A weight write blocks input in that cycle.
- A vector is accepted when in_valid && in_ready.
- While adv=0, every stage register, the accumulator and the out_* registers hold.
- Stage k (k=0..NUM_PE-1) registers psum_k = psum_{k-1} + sext(x_k*w_k); psum_{-1}=0.
  - Stage 0 captures on the acceptance edge.
  - Each stage carries the not-yet-consumed elements plus the first/last flags and a valid bit.
  - Bubbles propagate with valid=0.
- Products: signed DATA_WIDTH x DATA_WIDTH, full 2*DATA_WIDTH, sign-extended to ACC_WIDTH. All adds wrap modulo 2^ACC_WIDTH; no internal saturation.
- Accumulate step, on the edge where the last stage's valid vector advances:
  - acc <= first ? psum : acc + psum.
  - If last: out_valid<=1 and out_data/out_sat loaded from the combinational round/sat of the new acc value.
  - If not last: out_* unchanged.
- Latency: the vector accepted at edge T with in_last=1 gives out_valid=1 after edge T+NUM_PE, assuming no stall.
- Throughput: one vector per cycle.
- last without a preceding first: accumulates onto the current acc (0 after reset).
- first && last together: single-tile dot product.
- Round/saturate:
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, round half up, arithmetic shift.
  - If r > 2^(OUT_WIDTH-1)-1: out_data = max, out_sat=1.
  - If r < -2^(OUT_WIDTH-1): out_data = min, out_sat=1.
  - Otherwise out_data = r, out_sat=0.
- Output handshake:
  - out_valid clears on the out_valid && out_ready edge unless a new result loads on that same edge.
  - out_data is stable while out_valid && !out_ready.
- Weights:
  - w_we && !busy writes w_data into weight[w_idx] at the edge.
  - w_we && busy ignores the write and sets w_err=1 (sticky until reset).
  - w_we while out_valid=1 but busy=0 is legal.
- busy = OR of stage valid bits; it does not include out_valid.

Decomposition:
- Shared package mac_pkg holds:
  - clog2 helper.
  - Rounding/saturation function sat_round(acc, FRAC_BITS, OUT_WIDTH), returning value and sat flag.
  - Localparams OUT_MAX/OUT_MIN.
- One sub-module, mac_stage: a single registered MAC stage with valid, enable (adv), weight, psum in/out and element forwarding. Instantiate NUM_PE times via generate.

Test Plan:
- Single tile, full cycle (weights = 1.0):
  - Write weights 256,256,256,256.
  - Apply x=[256,512,-256,128] with first=last=1.
  - Expect out_data=640 (2.5), out_sat=0, out_valid exactly NUM_PE cycles after acceptance.
- Two-tile accumulate:
  - Apply tile A (first=1,last=0) x=[256,0,0,0], then tile B (first=0,last=1) x=[0,256,0,0], same weights.
  - Expect a single output 512; no output after tile A.
- Rounding and saturation, with weight[0]=128, others 0:
  - x0=1 gives out 1; x0=-1 gives out 0.
  - All weights and data 2047 gives out 2047, sat=1.
  - Data -2048, weights 2047 gives out -2048, sat=1.
- Backpressure:
  - Stream 6 back-to-back single-tile vectors with out_ready low for 3 cycles mid-stream.
  - Expect in_ready low while stalled, no lost or duplicated results, out_data stable during stall, results in order.
- Weight write while busy:
  - Assert w_we one cycle after acceptance.
  - Expect the weight unchanged, w_err=1, and the result computed with the old weights.
  - Assert w_we with in_valid=1: expect in_ready=0 that cycle.
- Reset mid-operation:
  - Assert rst_n=0 with 3 vectors in flight.
  - Expect out_valid=0, busy=0, w_err=0, weights 0 immediately.
  - After release, a new tile produces the correct result.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC row: index-width helper and the
// round-half-up / saturate step that turns an accumulator into a result.
package mac_pkg;

   localparam int WIDE_W        = 64;
   localparam int DEF_OUT_WIDTH = 12;
   localparam logic signed [WIDE_W-1:0] OUT_MAX = (64'sd1 <<< (DEF_OUT_WIDTH - 1)) - 64'sd1;
   localparam logic signed [WIDE_W-1:0] OUT_MIN = -(64'sd1 <<< (DEF_OUT_WIDTH - 1));

   typedef struct packed {
      logic signed [WIDE_W-1:0] value;
      logic                     sat;
   } sat_res_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // acc arrives sign-extended to WIDE_W, so the rounding add cannot overflow.
   function automatic sat_res_t sat_round(input logic signed [WIDE_W-1:0] acc,
                                          input int frac_bits, input int out_width);
      logic signed [WIDE_W-1:0] r;
      logic signed [WIDE_W-1:0] mx;
      logic signed [WIDE_W-1:0] mn;
      sat_res_t                 res;
      r  = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
      mx = (64'sd1 <<< (out_width - 1)) - 64'sd1;
      mn = -(64'sd1 <<< (out_width - 1));
      if (r > mx) begin
         res.value = mx;
         res.sat   = 1'b1;
      end else if (r < mn) begin
         res.value = mn;
         res.sat   = 1'b1;
      end else begin
         res.value = r;
         res.sat   = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/mac_pe_row_if.sv
// Input-vector and result streams of the MAC row, each a valid/ready pair.
interface mac_pe_row_if #(
   parameter int NUM_PE     = 4,
   parameter int DATA_WIDTH = 12,
   parameter int OUT_WIDTH  = 12
);
   logic                           in_valid;
   logic                           in_ready;
   logic [NUM_PE*DATA_WIDTH-1:0]   in_data;
   logic                           in_first;
   logic                           in_last;
   logic                           out_valid;
   logic                           out_ready;
   logic signed [OUT_WIDTH-1:0]    out_data;
   logic                           out_sat;

   modport slave (
      input  in_valid, in_data, in_first, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

   modport master (
      output in_valid, in_data, in_first, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/mac_stage.sv
// One registered MAC stage: adds x[IDX]*weight to the incoming partial sum
// and forwards the vector, tile flags and valid bit to the next stage.
module mac_stage #(
   parameter int NUM_PE     = 4,
   parameter int DATA_WIDTH = 12,
   parameter int ACC_WIDTH  = 32,
   parameter int IDX        = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en_i,
   input  logic                           valid_i,
   input  logic                           first_i,
   input  logic                           last_i,
   input  logic [NUM_PE*DATA_WIDTH-1:0]   data_i,
   input  logic signed [ACC_WIDTH-1:0]    psum_i,
   input  logic signed [DATA_WIDTH-1:0]   weight_i,
   output logic                           valid_o,
   output logic                           first_o,
   output logic                           last_o,
   output logic [NUM_PE*DATA_WIDTH-1:0]   data_o,
   output logic signed [ACC_WIDTH-1:0]    psum_o
);
   localparam int PW = 2 * DATA_WIDTH;

   logic signed [DATA_WIDTH-1:0] x;
   logic signed [PW-1:0]         prod;
   logic signed [ACC_WIDTH-1:0]  psum_d;
   logic                         valid_q, first_q, last_q;
   logic [NUM_PE*DATA_WIDTH-1:0] data_q;
   logic signed [ACC_WIDTH-1:0]  psum_q;

   assign x      = data_i[IDX*DATA_WIDTH +: DATA_WIDTH];
   assign prod   = x * weight_i;
   assign psum_d = psum_i + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         psum_q  <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         first_q <= first_i;
         last_q  <= last_i;
         data_q  <= data_i;
         psum_q  <= psum_d;
      end
   end

   assign valid_o = valid_q;
   assign first_o = first_q;
   assign last_o  = last_q;
   assign data_o  = data_q;
   assign psum_o  = psum_q;
endmodule

// File: rtl/mac_pe_row.sv
// Weight-stationary row of NUM_PE MAC stages with tile accumulation,
// round/saturate output and whole-row backpressure.
module mac_pe_row
   import mac_pkg::*;
#(
   parameter int NUM_PE     = 4,
   parameter int DATA_WIDTH = 12,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 12,
   parameter int FRAC_BITS  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          w_we,
   input  logic [clog2(NUM_PE)-1:0]      w_idx,
   input  logic signed [DATA_WIDTH-1:0]  w_data,
   output logic                          w_err,
   output logic                          busy,
   mac_pe_row_if.slave                   bus
);
   localparam int IDX_W = clog2(NUM_PE);

   logic [NUM_PE:0]              valid_c, first_c, last_c;
   logic [NUM_PE*DATA_WIDTH-1:0] data_c [NUM_PE+1];
   logic signed [ACC_WIDTH-1:0]  psum_c [NUM_PE+1];
   logic                         adv, accept;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                         out_valid_q, out_sat_q, w_err_q;
   logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;
   sat_res_t                     sr;

   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv && !w_we;
   assign accept       = bus.in_valid && bus.in_ready;

   assign valid_c[0] = accept;
   assign first_c[0] = bus.in_first;
   assign last_c[0]  = bus.in_last;
   assign data_c[0]  = bus.in_data;
   assign psum_c[0]  = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
         logic signed [DATA_WIDTH-1:0] weight_q;

         // Weights only change while the pipeline is empty, so in-flight vectors see one set.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) weight_q <= '0;
            else if (w_we && !busy && w_idx == IDX_W'(gi)) weight_q <= w_data;
         end

         mac_stage #(
            .NUM_PE(NUM_PE), .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .IDX(gi)
         ) u_stage (
            .clk(clk), .rst_n(rst_n), .en_i(adv),
            .valid_i(valid_c[gi]), .first_i(first_c[gi]), .last_i(last_c[gi]),
            .data_i(data_c[gi]), .psum_i(psum_c[gi]), .weight_i(weight_q),
            .valid_o(valid_c[gi+1]), .first_o(first_c[gi+1]), .last_o(last_c[gi+1]),
            .data_o(data_c[gi+1]), .psum_o(psum_c[gi+1])
         );
      end
   endgenerate

   assign busy  = |valid_c[NUM_PE:1];
   assign acc_d = first_c[NUM_PE] ? psum_c[NUM_PE] : acc_q + psum_c[NUM_PE];
   assign sr    = sat_round({{(WIDE_W-ACC_WIDTH){acc_d[ACC_WIDTH-1]}}, acc_d}, FRAC_BITS, OUT_WIDTH);
   assign out_data_d = OUT_WIDTH'(sr.value);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         w_err_q     <= 1'b0;
      end else begin
         if (w_we && busy) w_err_q <= 1'b1;
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         // A result loading on the handshake edge overrides the clear above.
         if (adv && valid_c[NUM_PE]) begin
            acc_q <= acc_d;
            if (last_c[NUM_PE]) begin
               out_valid_q <= 1'b1;
               out_data_q  <= out_data_d;
               out_sat_q   <= sr.sat;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign w_err         = w_err_q;
endmodule

// File: tb/tb_mac_pe_row.sv
// Directed bench for mac_pe_row: dot-product scoreboard plus literal checks.
module tb_mac_pe_row;
   import mac_pkg::*;

   localparam int NUM_PE = 4;
   localparam int DW     = 12;
   localparam int AW     = 32;
   localparam int OW     = 12;
   localparam int FB     = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 w_we;
   logic [1:0]           w_idx;
   logic signed [DW-1:0] w_data;
   logic                 w_err, busy;

   mac_pe_row_if #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

   mac_pe_row #(
      .NUM_PE(NUM_PE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .FRAC_BITS(FB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_idx(w_idx), .w_data(w_data),
      .w_err(w_err), .busy(busy), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: weights, running dot product, expected result queue.
   typedef struct { int data; bit sat; } exp_t;
   int   m_w [NUM_PE];
   int   m_acc;
   bit   m_werr;
   exp_t exp_q [$];
   bit   prev_stall;
   int   prev_data;
   bit   prev_sat;

   function automatic exp_t model_out(input int acc);
      longint t, r, half, div;
      exp_t   e;
      half = longint'(1) << (FB - 1);
      div  = longint'(1) << FB;
      t    = longint'(acc) + half;
      r    = (t >= 0) ? t / div : -((-t + div - 1) / div);
      if (r > 2047)       begin e.data = 2047;  e.sat = 1'b1; end
      else if (r < -2048) begin e.data = -2048; e.sat = 1'b1; end
      else                begin e.data = int'(r); e.sat = 1'b0; end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_acc      = 0;
         m_werr     = 1'b0;
         prev_stall = 1'b0;
         for (int i = 0; i < NUM_PE; i++) m_w[i] = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_held", bus.out_valid, 1);
            chk("stall_data_held", bus.out_data, prev_data);
            chk("stall_sat_held", bus.out_sat, prev_sat);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_sat   = bus.out_sat;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_out_data", bus.out_data, e.data);
               chk("sb_out_sat", bus.out_sat, e.sat);
            end
         end
         chk("in_ready_rule", bus.in_ready, (!bus.out_valid || bus.out_ready) && !w_we);
         chk("w_err_model", w_err, m_werr);
         if (bus.in_valid && bus.in_ready) begin
            longint dot;
            dot = 0;
            for (int i = 0; i < NUM_PE; i++)
               dot += longint'($signed(bus.in_data[i*DW +: DW])) * longint'(m_w[i]);
            m_acc = bus.in_first ? int'(dot) : m_acc + int'(dot);
            if (bus.in_last) exp_q.push_back(model_out(m_acc));
         end
         if (w_we) begin
            if (busy) m_werr = 1'b1;
            else m_w[w_idx] = int'(w_data);
         end
      end
   end

   // All tasks start and end #1 after a rising edge.
   task automatic wr_w(input int idx, input int val);
      w_we = 1'b1; w_idx = 2'(idx); w_data = DW'(val);
      @(posedge clk); #1;
      w_we = 1'b0;
   endtask

   task automatic set_vec(input int x0, x1, x2, x3, input bit f, input bit l);
      bus.in_data[0*DW +: DW] = DW'(x0);
      bus.in_data[1*DW +: DW] = DW'(x1);
      bus.in_data[2*DW +: DW] = DW'(x2);
      bus.in_data[3*DW +: DW] = DW'(x3);
      bus.in_first = f; bus.in_last = l; bus.in_valid = 1'b1;
   endtask

   task automatic send(input int x0, x1, x2, x3, input bit f, input bit l);
      int n;
      set_vec(x0, x1, x2, x3, f, l);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.in_ready && n < 100);
      if (!bus.in_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat, output int d, output bit s);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.out_valid && n < 100);
      if (!bus.out_valid) chk("out_timeout", 0, 1);
      lat = n - 1; d = bus.out_data; s = bus.out_sat;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_all_w(input int v);
      for (int i = 0; i < NUM_PE; i++) wr_w(i, v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, d;
      bit s;
      rst_n = 1'b0; w_we = 1'b0; w_idx = '0; w_data = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_first = 1'b0; bus.in_last = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_sat", bus.out_sat, 0);
      chk("rst_w_err", w_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      rst_n = 1'b1;
      idle(1);

      // Single tile with unit weights
      set_all_w(256);
      send(256, 512, -256, 128, 1, 1);
      wait_out(lat, d, s);
      chk("t1_data", d, 640);
      chk("t1_sat", s, 0);
      chk("t1_latency", lat, NUM_PE);

      // Two tiles into one result
      send(256, 0, 0, 0, 1, 0);
      send(0, 256, 0, 0, 0, 1);
      wait_out(lat, d, s);
      chk("t2_data", d, 512);
      chk("t2_latency_after_b", lat, NUM_PE);

      // Rounding and saturation
      wr_w(0, 128); wr_w(1, 0); wr_w(2, 0); wr_w(3, 0);
      send(1, 0, 0, 0, 1, 1);
      wait_out(lat, d, s);
      chk("round_up_half", d, 1);
      send(-1, 0, 0, 0, 1, 1);
      wait_out(lat, d, s);
      chk("round_neg_half", d, 0);
      set_all_w(2047);
      send(2047, 2047, 2047, 2047, 1, 1);
      wait_out(lat, d, s);
      chk("sat_pos_data", d, 2047);
      chk("sat_pos_flag", s, 1);
      send(-2048, -2048, -2048, -2048, 1, 1);
      wait_out(lat, d, s);
      chk("sat_neg_data", d, -2048);
      chk("sat_neg_flag", s, 1);

      // Back-to-back stream with a 3-cycle downstream stall
      set_all_w(256);
      fork
         begin
            for (int i = 1; i <= 6; i++) send(i * 256, 0, 0, 0, 1, 1);
         end
         begin
            idle(6);
            bus.out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", bus.in_ready, 0);
               chk("stall_out_valid", bus.out_valid, 1);
               @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      idle(12);
      chk("stream_all_delivered", exp_q.size(), 0);

      // Weight write attempted while busy
      send(256, 256, 256, 256, 1, 1);
      wr_w(0, 512);
      wait_out(lat, d, s);
      chk("busy_write_old_w", d, 1024);
      chk("busy_write_w_err", w_err, 1);
      send(256, 0, 0, 0, 1, 1);
      wait_out(lat, d, s);
      chk("busy_write_w0_kept", d, 256);
      idle(2);
      set_vec(0, 256, 0, 0, 1, 1);
      w_we = 1'b1; w_idx = 2'd1; w_data = 12'sd256;
      @(negedge clk);
      chk("w_we_blocks_in", bus.in_ready, 0);
      @(posedge clk); #1;
      w_we = 1'b0;
      send(0, 256, 0, 0, 1, 1);
      wait_out(lat, d, s);
      chk("after_w_we_result", d, 256);

      // Reset with three vectors in flight
      send(256, 0, 0, 0, 1, 1);
      send(512, 0, 0, 0, 1, 1);
      send(768, 0, 0, 0, 1, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_w_err", w_err, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);
      send(256, 256, 0, 0, 1, 1);
      wait_out(lat, d, s);
      chk("post_rst_zero_w", d, 0);
      set_all_w(256);
      send(256, 256, 0, 0, 1, 1);
      wait_out(lat, d, s);
      chk("post_rst_result", d, 512);

      idle(8);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
